// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared definitions for the CPU trace buffer.
//   - state_t      : capture FSM encoding (also exported on the state port)
//   - TRIG_*       : trigger-mode encodings for trig_mode
//   - entry_w()    : width of one packed trace entry
//   - OFF_*/off_*(): bit offsets of each field inside a packed entry
//     Entry layout, MSB to LSB: {pc, instr, we, waddr, wdata}
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_IMM   = 2'd0;  // first sample after arm
  localparam logic [1:0] TRIG_PC    = 2'd1;  // pc_in == trig_pc
  localparam logic [1:0] TRIG_REG   = 2'd2;  // rf_we_in && rf_waddr_in == trig_reg
  localparam logic [1:0] TRIG_PC_WE = 2'd3;  // pc_in == trig_pc && rf_we_in

  function automatic int entry_w(int pc_w, int data_w, int raddr_w);
    return pc_w + 2 * data_w + raddr_w + 1;
  endfunction

  localparam int OFF_WDATA = 0;

  function automatic int off_waddr(int data_w);
    return data_w;
  endfunction

  function automatic int off_we(int data_w, int raddr_w);
    return data_w + raddr_w;
  endfunction

  function automatic int off_instr(int data_w, int raddr_w);
    return data_w + raddr_w + 1;
  endfunction

  function automatic int off_pc(int data_w, int raddr_w);
    return 2 * data_w + raddr_w + 1;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: control, probe, readout and status signals of the
// trace buffer.
//   master : the bench / debug bridge / CPU probe side (drives controls,
//            probes and read requests; observes readout and status)
//   slave  : the trace buffer itself
// Readout handshake: rd_en is a request with no back-pressure (the buffer
// accepts one read every cycle); rd_valid is a one-cycle pulse exactly one
// clock after the accepting edge and qualifies rd_data, which then holds
// until the next accepted read.
interface cpu_trace_buffer_if
  import cpu_trace_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 64
);
  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = entry_w(PC_W, DATA_W, RADDR_W);

  logic               arm;
  logic               abort;
  logic [1:0]         trig_mode;
  logic [PC_W-1:0]    trig_pc;
  logic [RADDR_W-1:0] trig_reg;
  logic [AW:0]        post_count;
  logic               sample_en;
  logic [PC_W-1:0]    pc_in;
  logic [DATA_W-1:0]  instr_in;
  logic               rf_we_in;
  logic [RADDR_W-1:0] rf_waddr_in;
  logic [DATA_W-1:0]  rf_wdata_in;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid;
  logic [1:0]         state;
  logic               triggered;
  logic               done;
  logic [AW:0]        count;
  logic [AW-1:0]      trig_index;

  modport master (
    output arm, abort, trig_mode, trig_pc, trig_reg, post_count, sample_en,
           pc_in, instr_in, rf_we_in, rf_waddr_in, rf_wdata_in, rd_en, rd_addr,
    input  rd_data, rd_valid, state, triggered, done, count, trig_index
  );

  modport slave (
    input  arm, abort, trig_mode, trig_pc, trig_reg, post_count, sample_en,
           pc_in, instr_in, rf_we_in, rf_waddr_in, rf_wdata_in, rd_en, rd_addr,
    output rd_data, rd_valid, state, triggered, done, count, trig_index
  );

endinterface

// File: rtl/cpu_trace_ram.sv
// cpu_trace_ram: simple dual-port RAM, 2**ADDR_W x WIDTH.
//   clk          : clock
//   we/waddr/wdata: write port
//   re/raddr     : read request; rdata updates one clock later and holds
// A read of the address being written in the same cycle returns the old
// contents. No reset on the array or read register so it maps to block RAM.
module cpu_trace_ram #(
  parameter int WIDTH  = 78,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: triggerable circular capture of the CPU debug probes.
//   MAX10_CLK1_50 : clock (rising edge)
//   reset         : asynchronous, active-high
//   bus (slave)   : arm/abort, trigger setup, probe inputs, readout port and
//                   status (state, triggered, done, count, trig_index)
// IDLE -arm-> ARMED -trigger-> POST -post_count samples-> DONE.
// Logical read index 0 is always the oldest stored entry.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 64
) (
  input  logic        MAX10_CLK1_50,
  input  logic        reset,
  cpu_trace_buffer_if.slave bus
);

  localparam int AW        = $clog2(DEPTH);
  localparam int ENTRY_W   = entry_w(PC_W, DATA_W, RADDR_W);
  localparam int OFF_WADDR = off_waddr(DATA_W);
  localparam int OFF_WE    = off_we(DATA_W, RADDR_W);
  localparam int OFF_INSTR = off_instr(DATA_W, RADDR_W);
  localparam int OFF_PC    = off_pc(DATA_W, RADDR_W);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] MAX_POST = (AW+1)'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr, trig_ptr, remaining, post_eff;
  logic [AW:0]        count;
  logic               triggered;
  logic [1:0]         mode_q;
  logic [PC_W-1:0]    tpc_q;
  logic [RADDR_W-1:0] treg_q;
  logic               start, wr_en, hit;
  logic [ENTRY_W-1:0] wr_entry, ram_q;
  logic [AW-1:0]      oldest, rd_phys;
  logic               rd_valid_q, rd_zero_q;

  // Trigger compare against the values latched at arm time.
  always_comb begin
    hit = 1'b0;
    case (mode_q)
      TRIG_IMM:   hit = 1'b1;
      TRIG_PC:    hit = (bus.pc_in == tpc_q);
      TRIG_REG:   hit = bus.rf_we_in && (bus.rf_waddr_in == treg_q);
      TRIG_PC_WE: hit = (bus.pc_in == tpc_q) && bus.rf_we_in;
      default:    hit = 1'b0;
    endcase
  end

  // Next state. abort beats arm; arm restarts from any state and the arm
  // cycle itself never writes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    wr_en   = 1'b0;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else if (bus.arm) begin
      state_d = ST_ARMED;
      start   = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED: if (bus.sample_en) begin
          wr_en = 1'b1;
          if (hit) state_d = (post_eff == '0) ? ST_DONE : ST_POST;
        end
        ST_POST: if (bus.sample_en) begin
          wr_en = 1'b1;
          if (remaining == AW'(1)) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      triggered <= 1'b0;
      trig_ptr  <= '0;
      remaining <= '0;
      post_eff  <= '0;
      mode_q    <= TRIG_IMM;
      tpc_q     <= '0;
      treg_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        wr_ptr    <= '0;
        count     <= '0;
        triggered <= 1'b0;
        // A post window of DEPTH would overwrite the trigger sample itself.
        post_eff  <= (bus.post_count > MAX_POST) ? MAX_POST[AW-1:0]
                                                 : bus.post_count[AW-1:0];
        mode_q    <= bus.trig_mode;
        tpc_q     <= bus.trig_pc;
        treg_q    <= bus.trig_reg;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count != DEPTH_C) count <= count + 1'b1;
        if (state_q == ST_ARMED && hit) begin
          trig_ptr  <= wr_ptr;
          triggered <= 1'b1;
          remaining <= post_eff;
        end else if (state_q == ST_POST) begin
          remaining <= remaining - 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_entry = '0;
    wr_entry[OFF_PC    +: PC_W]    = bus.pc_in;
    wr_entry[OFF_INSTR +: DATA_W]  = bus.instr_in;
    wr_entry[OFF_WE]               = bus.rf_we_in;
    wr_entry[OFF_WADDR +: RADDR_W] = bus.rf_waddr_in;
    wr_entry[OFF_WDATA +: DATA_W]  = bus.rf_wdata_in;
  end

  // count only reaches DEPTH (top bit set) once the buffer has wrapped; from
  // then on the next slot to be written is also the oldest one.
  assign oldest  = count[AW] ? wr_ptr : '0;
  assign rd_phys = oldest + bus.rd_addr;

  cpu_trace_ram #(
    .WIDTH  (ENTRY_W),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (MAX10_CLK1_50),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .re    (bus.rd_en),
    .raddr (rd_phys),
    .rdata (ram_q)
  );

  // rd_zero_q masks reads past the stored window and also keeps rd_data at
  // zero after reset, since the RAM read register itself is not reset.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_zero_q <= ({1'b0, bus.rd_addr} >= count);
    end
  end

  assign bus.rd_data    = rd_zero_q ? '0 : ram_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.state      = state_q;
  assign bus.triggered  = triggered;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.count      = count;
  assign bus.trig_index = trig_ptr - oldest;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
module tb_cpu_trace_buffer;

  localparam int PC_W    = 8;
  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int ENTRY_W = PC_W + 2 * DATA_W + RADDR_W + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_trace_buffer_if #(
    .PC_W(PC_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W), .DEPTH(DEPTH)
  ) bus ();

  cpu_trace_buffer #(
    .PC_W(PC_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W), .DEPTH(DEPTH)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .bus           (bus)
  );

  logic [ENTRY_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [PC_W-1:0] pc;
    bit              en;
    logic [1:0]      st;
    logic [AW:0]     cnt;
  } smp_vec_t;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [PC_W-1:0] pc;
    bit              zero;
  } rd_vec_t;

  smp_vec_t sv[5];
  rd_vec_t  rv[6];

  function automatic logic [DATA_W-1:0] instr_of(logic [PC_W-1:0] pc);
    return {8'hC0, pc, ~pc, 8'h5A};
  endfunction

  function automatic logic [ENTRY_W-1:0] mk_entry(logic [PC_W-1:0] pc,
      logic [DATA_W-1:0] instr, logic we, logic [RADDR_W-1:0] waddr,
      logic [DATA_W-1:0] wdata);
    return {pc, instr, we, waddr, wdata};
  endfunction

  function automatic logic [ENTRY_W-1:0] ent_pc(logic [PC_W-1:0] pc);
    return mk_entry(pc, instr_of(pc), pc[0], pc[4:0], {pc, pc, pc, pc});
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(string tag, logic [1:0] st, logic [AW:0] cnt,
                              logic trg, logic dn);
    check({tag, ".state"},     128'(bus.state),     128'(st));
    check({tag, ".count"},     128'(bus.count),     128'(cnt));
    check({tag, ".triggered"}, 128'(bus.triggered), 128'(trg));
    check({tag, ".done"},      128'(bus.done),      128'(dn));
  endtask

  task automatic check_ti(string tag, logic [AW-1:0] ti);
    check({tag, ".trig_index"}, 128'(bus.trig_index), 128'(ti));
  endtask

  // One clock; the read scoreboard pops whenever the DUT presents rd_valid.
  task automatic tick();
    logic [ENTRY_W-1:0] e;
    @(posedge clk);
    #1;
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got rd_valid=1 data %0h expected no read",
                 bus.rd_data);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", 128'(bus.rd_data), 128'(e));
      end
    end
  endtask

  task automatic sample_full(logic [PC_W-1:0] pc, bit en, logic we,
                             logic [RADDR_W-1:0] waddr, logic [DATA_W-1:0] wdata);
    bus.sample_en   = en;
    bus.pc_in       = pc;
    bus.instr_in    = instr_of(pc);
    bus.rf_we_in    = we;
    bus.rf_waddr_in = waddr;
    bus.rf_wdata_in = wdata;
    tick();
    bus.sample_en = 1'b0;
    bus.rd_en     = 1'b0;
  endtask

  task automatic sample(logic [PC_W-1:0] pc, bit en);
    sample_full(pc, en, pc[0], pc[4:0], {pc, pc, pc, pc});
  endtask

  task automatic arm_cap(logic [1:0] mode, logic [PC_W-1:0] tpc,
                         logic [RADDR_W-1:0] treg, logic [AW:0] post);
    bus.arm        = 1'b1;
    bus.trig_mode  = mode;
    bus.trig_pc    = tpc;
    bus.trig_reg   = treg;
    bus.post_count = post;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic rd_start(logic [AW-1:0] addr, logic [ENTRY_W-1:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    exp_q.push_back(exp);
  endtask

  task automatic rd(logic [AW-1:0] addr, logic [ENTRY_W-1:0] exp);
    rd_start(addr, exp);
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    sv[0] = '{pc: 8'd0, en: 1'b1, st: 2'd2, cnt: 4'd1};
    sv[1] = '{pc: 8'd1, en: 1'b1, st: 2'd2, cnt: 4'd2};
    sv[2] = '{pc: 8'd2, en: 1'b1, st: 2'd2, cnt: 4'd3};
    sv[3] = '{pc: 8'd3, en: 1'b1, st: 2'd3, cnt: 4'd4};
    sv[4] = '{pc: 8'd4, en: 1'b1, st: 2'd3, cnt: 4'd4};
    rv[0] = '{addr: 3'd0, pc: 8'd0, zero: 1'b0};
    rv[1] = '{addr: 3'd1, pc: 8'd1, zero: 1'b0};
    rv[2] = '{addr: 3'd3, pc: 8'd3, zero: 1'b0};
    rv[3] = '{addr: 3'd4, pc: 8'd0, zero: 1'b1};
    rv[4] = '{addr: 3'd7, pc: 8'd0, zero: 1'b1};
    rv[5] = '{addr: 3'd2, pc: 8'd2, zero: 1'b0};

    bus.arm = 1'b0;  bus.abort = 1'b0;  bus.trig_mode = 2'd0;
    bus.trig_pc = '0; bus.trig_reg = '0; bus.post_count = '0;
    bus.sample_en = 1'b0; bus.pc_in = '0; bus.instr_in = '0;
    bus.rf_we_in = 1'b0; bus.rf_waddr_in = '0; bus.rf_wdata_in = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check_status("reset", 2'd0, 4'd0, 1'b0, 1'b0);
    check_ti("reset", 3'd0);
    check("reset.rd_data", 128'(bus.rd_data), 128'(0));
    check("reset.rd_valid", 128'(bus.rd_valid), 128'(0));
    reset = 1'b0;
    tick();

    // Immediate trigger, post 3, table-driven
    arm_cap(2'd0, 8'd0, 5'd0, 4'd3);
    check_status("imm_armed", 2'd1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sample(sv[i].pc, sv[i].en);
      check_status($sformatf("imm_smp%0d", i), sv[i].st, sv[i].cnt, 1'b1,
                   sv[i].st == 2'd3);
    end
    check_ti("imm", 3'd0);
    for (int i = 0; i < 6; i++) begin
      rd_start(rv[i].addr, rv[i].zero ? '0 : ent_pc(rv[i].pc));
      tick();
    end
    bus.rd_en = 1'b0;

    // Wrap with PC trigger at 20, post 2; read collides with a write at pc 12
    arm_cap(2'd1, 8'd20, 5'd0, 4'd2);
    for (int p = 0; p <= 22; p++) begin
      if (p == 12) rd_start(3'd0, ent_pc(8'd4));
      sample(8'(p), 1'b1);
      if (p == 19) check_status("wrap_pc19", 2'd1, 4'd8, 1'b0, 1'b0);
      if (p == 20) check_status("wrap_pc20", 2'd2, 4'd8, 1'b1, 1'b0);
    end
    check_status("wrap_done", 2'd3, 4'd8, 1'b1, 1'b1);
    check_ti("wrap", 3'd5);
    for (int i = 0; i < 8; i++) begin
      rd_start(3'(i), ent_pc(8'(15 + i)));
      tick();
    end
    bus.rd_en = 1'b0;

    // Register-write trigger on reg 9, post 1
    arm_cap(2'd2, 8'd0, 5'd9, 4'd1);
    sample_full(8'd0, 1'b1, 1'b0, 5'd9, 32'h1111_1111);
    check_status("reg_we0", 2'd1, 4'd1, 1'b0, 1'b0);
    sample_full(8'd1, 1'b1, 1'b1, 5'd5, 32'h2222_2222);
    check_status("reg_other", 2'd1, 4'd2, 1'b0, 1'b0);
    sample_full(8'd2, 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF);
    check_status("reg_hit", 2'd2, 4'd3, 1'b1, 1'b0);
    sample_full(8'd3, 1'b1, 1'b0, 5'd0, 32'h0);
    check_status("reg_done", 2'd3, 4'd4, 1'b1, 1'b1);
    check_ti("reg", 3'd2);
    rd(3'd2, mk_entry(8'd2, instr_of(8'd2), 1'b1, 5'd9, 32'hDEAD_BEEF));
    rd(3'd0, mk_entry(8'd0, instr_of(8'd0), 1'b0, 5'd9, 32'h1111_1111));

    // sample_en gating
    arm_cap(2'd0, 8'd0, 5'd0, 4'd2);
    for (int i = 0; i < 5; i++) sample(8'(10 + i), (i % 2) == 0);
    check_status("gate", 2'd3, 4'd3, 1'b1, 1'b1);
    rd(3'd0, ent_pc(8'd10));
    rd(3'd1, ent_pc(8'd12));
    rd(3'd2, ent_pc(8'd14));
    rd(3'd3, '0);

    // post_count = DEPTH clamps to DEPTH-1
    arm_cap(2'd1, 8'd50, 5'd0, 4'd8);
    for (int p = 40; p <= 56; p++) sample(8'(p), 1'b1);
    check_status("clamp_pc56", 2'd2, 4'd8, 1'b1, 1'b0);
    sample(8'd57, 1'b1);
    check_status("clamp_done", 2'd3, 4'd8, 1'b1, 1'b1);
    check_ti("clamp", 3'd0);
    rd(3'd0, ent_pc(8'd50));
    rd(3'd7, ent_pc(8'd57));

    // arm and abort together: abort wins, buffer and count retained
    bus.arm = 1'b1;
    bus.abort = 1'b1;
    bus.trig_mode = 2'd0;
    tick();
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    check("abort.state", 128'(bus.state), 128'(0));
    check("abort.done", 128'(bus.done), 128'(0));
    check("abort.count", 128'(bus.count), 128'(8));
    check_ti("abort", 3'd0);
    sample(8'd70, 1'b1);
    check("idle_nowrite.count", 128'(bus.count), 128'(8));
    rd(3'd0, ent_pc(8'd50));

    // arm during POST restarts; the arm cycle does not write
    arm_cap(2'd0, 8'd0, 5'd0, 4'd5);
    sample(8'd100, 1'b1);
    sample(8'd101, 1'b1);
    check_status("post", 2'd2, 4'd2, 1'b1, 1'b0);
    bus.arm = 1'b1;
    sample(8'd102, 1'b1);
    bus.arm = 1'b0;
    check_status("rearm", 2'd1, 4'd0, 1'b0, 1'b0);
    sample(8'd103, 1'b1);
    check_status("rearm_trig", 2'd2, 4'd1, 1'b1, 1'b0);
    rd(3'd0, ent_pc(8'd103));

    // reset mid-POST
    bus.sample_en = 1'b1;
    bus.pc_in = 8'd104;
    #3;
    reset = 1'b1;
    tick();
    check_status("midreset", 2'd0, 4'd0, 1'b0, 1'b0);
    check_ti("midreset", 3'd0);
    check("midreset.rd_data", 128'(bus.rd_data), 128'(0));
    check("midreset.rd_valid", 128'(bus.rd_valid), 128'(0));
    reset = 1'b0;
    bus.sample_en = 1'b0;
    tick();

    // post_count 0: trigger sample goes straight to DONE
    arm_cap(2'd0, 8'd0, 5'd0, 4'd0);
    sample(8'd200, 1'b1);
    check_status("post0", 2'd3, 4'd1, 1'b1, 1'b1);
    rd(3'd0, ent_pc(8'd200));
    rd(3'd1, '0);

    // PC match AND write enable
    arm_cap(2'd3, 8'd7, 5'd0, 4'd0);
    sample_full(8'd7, 1'b1, 1'b0, 5'd3, 32'h0BAD_0BAD);
    check_status("pcwe_we0", 2'd1, 4'd1, 1'b0, 1'b0);
    sample_full(8'd7, 1'b1, 1'b1, 5'd3, 32'h1234_5678);
    check_status("pcwe_hit", 2'd3, 4'd2, 1'b1, 1'b1);
    check_ti("pcwe", 3'd1);
    rd(3'd1, mk_entry(8'd7, instr_of(8'd7), 1'b1, 5'd3, 32'h1234_5678));

    repeat (3) tick();
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Synthesizable on-chip trace capture for the single-cycle CPU, replacing the simulation-only `$monitor` flow with a triggerable, parametrised history of the CPU's debug probe signals. It sits beside `CPU`. It samples the fetch PC, instruction and register-file write-back each qualified cycle into a circular buffer. It stops a programmable number of samples after a trigger, and the captured window is then read back through a registered port by a bench or a JTAG/UART bridge.

## Interface
Parameters:
- `PC_W`, 8, width of PC probe
- `DATA_W`, 32, width of instruction and write-back data
- `RADDR_W`, 5, register address width
- `DEPTH`, 64, buffer entries; power of two, ≥ 4
- Derived: `AW = $clog2(DEPTH)`; `ENTRY_W = PC_W + 2*DATA_W + RADDR_W + 1` (78 at defaults)

Ports:
- `MAX10_CLK1_50`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; one clock, async active-high reset (fixed)
- `arm`  in  1  start or restart capture
- `abort`  in  1  return to IDLE; wins over `arm`
- `trig_mode`  in  2  0 immediate, 1 PC match, 2 register-write match, 3 PC match AND `rf_we_in`
- `trig_pc`  in  PC_W  PC compare value
- `trig_reg`  in  RADDR_W  write-address compare value
- `post_count`  in  AW+1  samples kept after the trigger sample
- `sample_en`  in  1  sample qualifier, e.g. `pc_increment_test`
- `pc_in`  in  PC_W;  `instr_in`  in  DATA_W;  `rf_we_in`  in  1;  `rf_waddr_in`  in  RADDR_W;  `rf_wdata_in`  in  DATA_W  probe inputs
- `rd_en`  in  1  readout request
- `rd_addr`  in  AW  logical index, 0 = oldest entry
- `rd_data`  out  ENTRY_W  packed entry {pc, instr, we, waddr, wdata}, MSB→LSB
- `rd_valid`  out  1  one-cycle pulse qualifying `rd_data`
- `state`  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- `triggered`  out  1  trigger has occurred in the current capture
- `done`  out  1  high in DONE
- `count`  out  AW+1  valid entries, saturates at DEPTH
- `trig_index`  out  AW  logical index of the trigger sample

## Operation
- IDLE: no writes. `arm` → ARMED. On that edge: clear `wr_ptr`, `count` and `triggered`; latch `post_eff = min(post_count, DEPTH-1)`, `trig_mode`, `trig_pc` and `trig_reg`.
- ARMED: on each `sample_en` cycle, write the entry at `wr_ptr` and increment `wr_ptr` mod DEPTH; `count` saturates. The trigger is evaluated on the same sample. On a hit: `trig_ptr ← wr_ptr`, `triggered ← 1`. Then go to DONE if `post_eff == 0`, else to POST with `remaining ← post_eff`.
- Trigger conditions: mode 0 = first sample after arm; mode 1 = `pc_in == trig_pc`; mode 2 = `rf_we_in && rf_waddr_in == trig_reg`; mode 3 = `pc_in == trig_pc && rf_we_in`.
- POST: each `sample_en` cycle writes and decrements `remaining`; the write that takes it to 0 moves the FSM to DONE.
- DONE: no writes; `done` = 1; `arm` restarts capture.
- `abort` (any state): → IDLE with `done` = 0. Buffer, `count` and `trig_index` are retained.
- `arm` in ARMED or POST restarts capture, as from IDLE.
- `arm` and `abort` in the same cycle: abort wins.
- Readout:
  - `oldest = (count < DEPTH) ? 0 : wr_ptr`; `phys = (oldest + rd_addr) mod DEPTH`.
  - `rd_addr ≥ count` returns all-zero `rd_data`, with `rd_valid` still pulsed.
  - Reads are legal in any state. A read colliding with a same-cycle write returns the old data.
- `trig_index = (trig_ptr − oldest) mod DEPTH`; meaningful only while `triggered` = 1.

## Timing
- All inputs are sampled on the rising edge. `state`, `count`, `triggered`, `trig_index` and `done` reflect a qualifying sample on the following cycle.
- Read latency: 1 cycle (`rd_en` at edge N → `rd_data`/`rd_valid` after edge N+1). Back-to-back reads every cycle are supported.
- Reset: `state` = IDLE; `rd_data`, `rd_valid`, `triggered`, `done`, `count`, `trig_index` and all pointers = 0. RAM contents are not reset.
- Reset asserted mid-capture aborts immediately, with no partial writes after assertion.

## Structure
- Package `cpu_trace_pkg` holds:
  - state encoding constants;
  - trigger-mode constants;
  - an `ENTRY_W` helper function;
  - entry field offsets.
- Sub-module `cpu_trace_ram`: simple dual-port, DEPTH × ENTRY_W, synchronous read, read-old-data on collision; must infer M9K.
- The top level contains the FSM, pointers, trigger compare and readout address arithmetic.

## Test plan
- Immediate trigger (`trig_mode` 0, `post_count` 3), `sample_en` = 1, `pc_in` 0,1,2,… → DONE after 4 samples; `count` = 4, `trig_index` = 0; `rd_addr` 0 → pc 0; `rd_addr` 3 → pc 3; `rd_addr` 4 → 0.
- Wrap (DEPTH = 8, `trig_mode` 1, `trig_pc` = 20, `post_count` = 2), pc 0..22 → `count` = 8, `trig_index` = 5; reads 0..7 return pc 15..22.
- Register match (`trig_mode` 2, `trig_reg` = 9): a write to reg 9 with `rf_we_in` = 0 does not trigger; with `rf_we_in` = 1 and wdata 0xDEADBEEF it triggers; `rd_addr` = `trig_index` returns that wdata.
- Gating and clamp: `sample_en` toggles 1,0,1,0 → only qualified cycles stored. `post_count` = DEPTH clamps to DEPTH−1, giving `trig_index` = 0 after wrap.
- Control conflicts:
  - `arm` and `abort` in the same cycle → IDLE;
  - `arm` during POST → `count` = 0, `triggered` = 0;
  - `reset` mid-POST → all outputs 0 on the next edge.
